serial_add_arbiter: RTL

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter in front of a single bit-serial adder.
// One full_adder is reused LSB-first for WIDTH cycles per granted operation.

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Carry
);
    assign Sum   = A ^ B ^ Cin;
    assign Carry = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             last_id_q, last_id_d;
    logic             owner_q, owner_d;
    logic             cout_q, cout_d;
    logic             done_id_q, done_id_d;
    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] res_shift;

    full_adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Carry(fa_carry)
    );

    // Shift-based insert at the MSB so the expression stays legal for WIDTH == 1.
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        last_id_d = last_id_q;
        owner_d   = owner_q;
        cout_d    = cout_q;
        done_id_d = done_id_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_id_q)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 || gnt1) begin
                    a_d       = gnt1 ? a1 : a0;
                    b_d       = gnt1 ? b1 : b0;
                    carry_d   = gnt1 ? cin1 : cin0;
                    cnt_d     = '0;
                    last_id_d = gnt1;
                    owner_d   = gnt1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                res_d   = res_shift;
                cnt_d   = cnt_q + CW'(1);
                // Results are captured on the last RUN edge so they are valid while done is high.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d     = res_shift;
                    cout_d    = fa_carry;
                    done_id_d = owner_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            last_id_q <= 1'b1;
            owner_q   <= 1'b0;
            cout_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            last_id_q <= last_id_d;
            owner_q   <= owner_d;
            cout_q    <= cout_d;
            done_id_q <= done_id_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign done_id = done_id_q;
endmodule
